// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if
//   Request/result bundle between the control unit and the iterative
//   multiply/divide unit.
//   master (control unit): drives start, op, is_signed, a, b;
//                          observes busy, done, hi, lo, div_by_zero.
//   slave  (mult_div_unit): the mirror image.
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op;
   logic             is_signed;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;

   modport master (
      output start, op, is_signed, a, b,
      input  busy, done, hi, lo, div_by_zero
   );

   modport slave (
      input  start, op, is_signed, a, b,
      output busy, done, hi, lo, div_by_zero
   );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative radix-2 multiply / restoring divide unit for the multicycle
//   datapath (mult, multu, div, divu). One shift/add or shift/subtract step
//   per clock; results land in hi/lo with a one-cycle done pulse.
//   Ports:
//     clock       rising-edge system clock
//     reset       synchronous, active-high
//     bus.start   request, sampled only while idle
//     bus.op      0 = multiply, 1 = divide
//     bus.is_signed  two's-complement operands when 1
//     bus.a/b     multiplicand,dividend / multiplier,divisor
//     bus.busy    high from the cycle after acceptance until done falls
//     bus.done    one-cycle pulse, results valid from this cycle
//     bus.hi/lo   product halves, or remainder / quotient
//     bus.div_by_zero  set with done on a divide by zero
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input logic            clock,
   input logic            reset,
   mult_div_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;      // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
   logic [WIDTH-1:0]   dvs;      // multiplicand or divisor magnitude
   logic               op_r, neg_q, neg_r, dz;
   logic               busy_r, done_r, dz_r;
   logic [WIDTH-1:0]   hi_r, lo_r;

   logic               a_neg, b_neg, accept, b_zero;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_sh;
   logic [WIDTH+1:0]   div_diff;
   logic [2*WIDTH-1:0] mul_nxt, div_nxt, prod;
   logic [WIDTH-1:0]   fix_hi, fix_lo;

   function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic n);
      return n ? (~v) + WIDTH'(1) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] v, input logic n);
      return n ? (~v) + (2*WIDTH)'(1) : v;
   endfunction

   assign accept = (state == IDLE) && bus.start;
   assign b_zero = (bus.b == '0);
   assign a_neg  = bus.is_signed & bus.a[WIDTH-1];
   assign b_neg  = bus.is_signed & bus.b[WIDTH-1];
   assign a_mag  = cneg(bus.a, a_neg);
   assign b_mag  = cneg(bus.b, b_neg);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.start) state_nxt = (bus.op && b_zero) ? FIX : RUN;
         RUN:  if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
         FIX:  state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Multiply step: add multiplicand when the multiplier LSB is set, then
   // shift the whole accumulator right, carry entering at the top.
   assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : '0);
   assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

   // Divide step: shift the next dividend bit into the remainder and keep
   // the trial subtraction only when it does not borrow.
   assign div_sh   = acc[2*WIDTH-1:WIDTH-1];
   assign div_diff = {1'b0, div_sh} - {2'b00, dvs};
   assign div_nxt  = div_diff[WIDTH+1] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

   always_comb begin
      prod   = cneg2(acc, neg_q);
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
      if (dz) begin
         fix_hi = acc[2*WIDTH-1:WIDTH];
         fix_lo = acc[WIDTH-1:0];
      end else if (op_r) begin
         fix_hi = cneg(acc[2*WIDTH-1:WIDTH], neg_r);
         fix_lo = cneg(acc[WIDTH-1:0], neg_q);
      end
   end

   // Datapath working registers: only meaningful while busy, so no reset.
   always_ff @(posedge clock) begin
      if (accept) begin
         op_r  <= bus.op;
         neg_q <= a_neg ^ b_neg;
         neg_r <= a_neg;
         dz    <= bus.op && b_zero;
         dvs   <= bus.op ? b_mag : a_mag;
         if (bus.op && b_zero)
            acc <= {bus.a, {WIDTH{1'b1}}};
         else if (bus.op)
            acc <= {{WIDTH{1'b0}}, a_mag};
         else
            acc <= {{WIDTH{1'b0}}, b_mag};
      end else if (state == RUN) begin
         acc <= op_r ? div_nxt : mul_nxt;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         dz_r   <= 1'b0;
         hi_r   <= '0;
         lo_r   <= '0;
      end else begin
         cnt    <= (state == RUN) ? cnt + CW'(1) : '0;
         busy_r <= (state_nxt != IDLE);
         done_r <= (state == FIX);
         if (accept) dz_r <= 1'b0;
         if (state == FIX) begin
            hi_r <= fix_hi;
            lo_r <= fix_lo;
            dz_r <= dz;
         end
      end
   end

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.hi          = hi_r;
   assign bus.lo          = lo_r;
   assign bus.div_by_zero = dz_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit at WIDTH=32: directed cases plus
//   randomized operations compared against a plain-arithmetic reference.
module tb_mult_div_unit;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   mult_div_unit_if #(.WIDTH(32)) bus ();

   mult_div_unit #(.WIDTH(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference results straight from the arithmetic definitions.
   function automatic void model(input logic o, input logic s,
                                 input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] eh, output logic [31:0] el,
                                 output logic ez);
      longint      sx, sy, p, q, r;
      logic [63:0] up;
      ez = 1'b0;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (!o) begin
         if (s) begin
            p = sx * sy;
            {eh, el} = p;
         end else begin
            up = {32'h0, x} * {32'h0, y};
            {eh, el} = up;
         end
      end else if (y == 32'h0) begin
         el = 32'hFFFF_FFFF;
         eh = x;
         ez = 1'b1;
      end else if (s) begin
         q  = sx / sy;
         r  = sx % sy;
         el = q[31:0];
         eh = r[31:0];
      end else begin
         el = x / y;
         eh = x % y;
      end
   endfunction

   task automatic wait_done(input string tag, output int lat);
      lat = 1;
      while (!bus.done && lat < 100) begin
         @(posedge clock); #1;
         lat++;
      end
      if (!bus.done) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic run_op(input logic o, input logic s, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] eh, el, ph, pl;
      logic        ez, hold_bad, busy_bad;
      int          lat, exp_lat;
      model(o, s, x, y, eh, el, ez);
      exp_lat = (o && y == 32'h0) ? 2 : 34;
      @(posedge clock); #1;
      bus.start = 1'b1; bus.op = o; bus.is_signed = s; bus.a = x; bus.b = y;
      ph = bus.hi; pl = bus.lo;
      @(posedge clock); #1;
      bus.start = 1'b0;
      bus.a = $urandom; bus.b = $urandom;
      bus.op = 1'($urandom); bus.is_signed = 1'($urandom);
      check("dz_clr", bus.div_by_zero, 0);
      lat = 1; hold_bad = 0; busy_bad = 0;
      while (!bus.done && lat < 100) begin
         if (!bus.busy) busy_bad = 1;
         if (bus.hi !== ph || bus.lo !== pl) hold_bad = 1;
         @(posedge clock); #1;
         lat++;
      end
      check("lat", lat, exp_lat);
      check("busy_run", busy_bad, 0);
      check("hold", hold_bad, 0);
      check("hi", bus.hi, eh);
      check("lo", bus.lo, el);
      check("dz", bus.div_by_zero, ez);
      check("busy_done", bus.busy, 1);
      @(posedge clock); #1;
      check("done_pulse", bus.done, 0);
      check("busy_end", bus.busy, 0);
   endtask

   logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

   initial begin
      logic [31:0] eh, el, x, y;
      logic        ez, o, s;
      int          lat;

      bus.start = 1'b0; bus.op = 1'b0; bus.is_signed = 1'b0; bus.a = '0; bus.b = '0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_hi", bus.hi, 0);
      check("rst_lo", bus.lo, 0);
      check("rst_dz", bus.div_by_zero, 0);
      reset = 1'b0;

      // Directed cases
      run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'h7);
      run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'h2);
      run_op(1'b1, 1'b1, 32'h7, 32'hFFFF_FFFE);
      run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(1'b1, 1'b0, 32'h5, 32'h0);
      run_op(1'b1, 1'b0, 32'h64, 32'h7);

      // Start held high with operands churning after acceptance
      model(1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, eh, el, ez);
      @(posedge clock); #1;
      bus.start = 1'b1; bus.op = 1'b0; bus.is_signed = 1'b0;
      bus.a = 32'h1234_5678; bus.b = 32'h9ABC_DEF0;
      @(posedge clock); #1;
      lat = 1;
      while (!bus.done && lat < 100) begin
         bus.a = $urandom; bus.b = $urandom;
         @(posedge clock); #1;
         lat++;
      end
      check("hold_lat", lat, 34);
      check("hold_hi", bus.hi, eh);
      check("hold_lo", bus.lo, el);
      bus.op = 1'b1; bus.is_signed = 1'b1; bus.a = 32'hFFFF_FF9C; bus.b = 32'h7;
      @(posedge clock); #1;
      check("hold_idle_busy", bus.busy, 0);
      check("hold_idle_done", bus.done, 0);
      @(posedge clock); #1;
      check("hold_restart", bus.busy, 1);
      bus.start = 1'b0;
      model(1'b1, 1'b1, 32'hFFFF_FF9C, 32'h7, eh, el, ez);
      wait_done("hold2", lat);
      check("hold2_lat", lat, 34);
      check("hold2_hi", bus.hi, eh);
      check("hold2_lo", bus.lo, el);

      // Reset in the middle of the iterations
      @(posedge clock); #1;
      bus.start = 1'b1; bus.op = 1'b0; bus.is_signed = 1'b1; bus.a = 32'h0BAD_F00D; bus.b = 32'h3;
      @(posedge clock); #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("mrst_busy", bus.busy, 0);
      check("mrst_done", bus.done, 0);
      check("mrst_hi", bus.hi, 0);
      check("mrst_lo", bus.lo, 0);
      run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'h7);

      // Randomized operations
      for (int i = 0; i < 40; i++) begin
         o = 1'($urandom);
         s = 1'($urandom);
         x = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
         y = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
         if ($urandom_range(0, 2) == 0) y = y >> $urandom_range(0, 31);
         run_op(o, s, x, y);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
